// File: rtl/ex_mem_pipe_stage_if.sv
// EX->MEM link: upstream entry with valid/ready, downstream entry with valid/ready, flush and stall counter.
// master = surrounding pipeline (EX and MEM), slave = the pipe stage itself.
interface ex_mem_pipe_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_branch_target;
  logic                  in_zero;
  logic [DATA_W-1:0]     in_alu_result;
  logic [DATA_W-1:0]     in_store_data;
  logic [REG_ADDR_W-1:0] in_write_reg;
  logic                  in_mem_read;
  logic                  in_mem_write;
  logic                  in_branch;
  logic                  in_reg_write;
  logic                  in_mem_to_reg;
  logic                  in_jump;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_branch_target;
  logic                  out_zero;
  logic [DATA_W-1:0]     out_alu_result;
  logic [DATA_W-1:0]     out_store_data;
  logic [REG_ADDR_W-1:0] out_write_reg;
  logic                  out_mem_read;
  logic                  out_mem_write;
  logic                  out_branch;
  logic                  out_reg_write;
  logic                  out_mem_to_reg;
  logic                  out_jump;
  logic [CNT_W-1:0]      stall_count;

  // Handshake: a transfer happens on a clock edge where valid && ready are both high.
  // in_ready depends only on stage state; out_valid never depends on out_ready.
  modport master (
    output flush, in_valid, in_branch_target, in_zero, in_alu_result, in_store_data,
           in_write_reg, in_mem_read, in_mem_write, in_branch, in_reg_write,
           in_mem_to_reg, in_jump, out_ready,
    input  in_ready, out_valid, out_branch_target, out_zero, out_alu_result,
           out_store_data, out_write_reg, out_mem_read, out_mem_write, out_branch,
           out_reg_write, out_mem_to_reg, out_jump, stall_count
  );

  modport slave (
    input  flush, in_valid, in_branch_target, in_zero, in_alu_result, in_store_data,
           in_write_reg, in_mem_read, in_mem_write, in_branch, in_reg_write,
           in_mem_to_reg, in_jump, out_ready,
    output in_ready, out_valid, out_branch_target, out_zero, out_alu_result,
           out_store_data, out_write_reg, out_mem_read, out_mem_write, out_branch,
           out_reg_write, out_mem_to_reg, out_jump, stall_count
  );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with a one-entry skid buffer, flush, bubble gating
// and a saturating stall counter. All state updates on the falling clock edge.
module ex_mem_pipe_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input logic                 clock,
  input logic                 reset,
  ex_mem_pipe_stage_if.slave  bus
);

  typedef struct packed {
    logic [DATA_W-1:0]     branch_target;
    logic                  zero;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] write_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  jump;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t           in_e;
  entry_t           m;
  entry_t           s;
  logic             m_v;
  logic             s_v;
  logic [CNT_W-1:0] stall_count_q;
  logic             accept;
  logic             drain;

  assign in_e = {bus.in_branch_target, bus.in_zero, bus.in_alu_result, bus.in_store_data,
                 bus.in_write_reg, bus.in_mem_read, bus.in_mem_write, bus.in_branch,
                 bus.in_reg_write, bus.in_mem_to_reg, bus.in_jump};

  // Skid occupancy alone decides in_ready, so EX never sees a path from out_ready.
  assign accept = bus.in_valid && !s_v;
  assign drain  = m_v && bus.out_ready;

  always_ff @(negedge clock) begin
    if (reset) begin
      m_v           <= 1'b0;
      s_v           <= 1'b0;
      m             <= '0;
      s             <= '0;
      stall_count_q <= '0;
    end else if (bus.flush) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
    end else begin
      if (m_v && !bus.out_ready && stall_count_q != CNT_MAX)
        stall_count_q <= stall_count_q + 1'b1;
      if (drain || !m_v) begin
        // A full skid implies in_ready was low, so no accept can race the S->M move.
        if (s_v) begin
          m   <= s;
          m_v <= 1'b1;
          s_v <= 1'b0;
        end else begin
          if (accept) m <= in_e;
          m_v <= accept;
        end
      end else if (accept) begin
        s   <= in_e;
        s_v <= 1'b1;
      end
    end
  end

  assign bus.in_ready          = !s_v;
  assign bus.out_valid         = m_v;
  assign bus.stall_count       = stall_count_q;
  assign bus.out_branch_target = m.branch_target;
  assign bus.out_zero          = m.zero;
  assign bus.out_alu_result    = m.alu_result;
  assign bus.out_store_data    = m.store_data;
  assign bus.out_write_reg     = m.write_reg;
  // Control bits are masked so an empty stage reads as a clean bubble downstream.
  assign bus.out_mem_read      = m.mem_read   & m_v;
  assign bus.out_mem_write     = m.mem_write  & m_v;
  assign bus.out_branch        = m.branch     & m_v;
  assign bus.out_reg_write     = m.reg_write  & m_v;
  assign bus.out_mem_to_reg    = m.mem_to_reg & m_v;
  assign bus.out_jump          = m.jump       & m_v;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: directed scenarios plus random traffic against a
// queue-based model of in-flight entries (at most two held).
module tb_ex_mem_pipe_stage;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
  localparam int E_W        = 3 * DATA_W + 1 + REG_ADDR_W + 6;

  logic clock = 1'b0;
  logic reset_r = 1'b1;
  logic flush_r = 1'b0;
  logic valid_r = 1'b0;
  logic ordy_r  = 1'b0;
  logic [E_W-1:0] in_vec = '0;
  logic [E_W-1:0] out_vec;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [E_W-1:0] exp_q[$];
  logic [E_W-1:0] shown;
  bit             shown_known;
  int             exp_cnt;

  always #5 clock = ~clock;

  ex_mem_pipe_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus ();

  ex_mem_pipe_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset_r),
    .bus   (bus.slave)
  );

  assign bus.flush     = flush_r;
  assign bus.in_valid  = valid_r;
  assign bus.out_ready = ordy_r;
  assign {bus.in_branch_target, bus.in_zero, bus.in_alu_result, bus.in_store_data,
          bus.in_write_reg, bus.in_mem_read, bus.in_mem_write, bus.in_branch,
          bus.in_reg_write, bus.in_mem_to_reg, bus.in_jump} = in_vec;
  assign out_vec = {bus.out_branch_target, bus.out_zero, bus.out_alu_result, bus.out_store_data,
                    bus.out_write_reg, bus.out_mem_read, bus.out_mem_write, bus.out_branch,
                    bus.out_reg_write, bus.out_mem_to_reg, bus.out_jump};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [E_W-1:0] mk(input logic [DATA_W-1:0] alu, input logic [5:0] ctrl);
    logic [DATA_W-1:0]     bt = $urandom;
    logic [DATA_W-1:0]     sd = $urandom;
    logic                  z  = 1'($urandom_range(0, 1));
    logic [REG_ADDR_W-1:0] wr = REG_ADDR_W'($urandom_range(0, 31));
    return {bt, z, alu, sd, wr, ctrl};
  endfunction

  task automatic verify();
    check("out_valid", 128'(bus.out_valid), 128'(exp_q.size() > 0));
    check("in_ready", 128'(bus.in_ready), 128'(exp_q.size() < 2));
    check("stall_count", 128'(bus.stall_count), 128'(exp_cnt));
    if (exp_q.size() > 0) begin
      check("entry", 128'(out_vec), 128'(exp_q[0]));
    end else begin
      check("bubble_ctrl", 128'(out_vec[5:0]), 128'(0));
      if (shown_known) check("held_data", 128'(out_vec[E_W-1:6]), 128'(shown[E_W-1:6]));
    end
  endtask

  // Drive one cycle's inputs, let the falling edge happen, advance the model, check mid-cycle.
  task automatic cycle(input bit v, input logic [E_W-1:0] d, input bit ordy,
                       input bit fl = 1'b0, input bit rs = 1'b0);
    int sz;
    bit acc;
    bit drn;
    valid_r = v;
    in_vec  = d;
    ordy_r  = ordy;
    flush_r = fl;
    reset_r = rs;
    sz  = exp_q.size();
    acc = v && sz < 2;
    drn = sz > 0 && ordy;
    @(negedge clock);
    if (rs) begin
      exp_q.delete();
      exp_cnt     = 0;
      shown       = '0;
      shown_known = 1'b1;
    end else if (fl) begin
      exp_q.delete();
      shown_known = 1'b0;
    end else begin
      if (sz > 0 && !ordy && exp_cnt < CNT_MAX) exp_cnt++;
      if (drn) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(d);
      if (exp_q.size() > 0) begin
        shown       = exp_q[0];
        shown_known = 1'b1;
      end
    end
    @(posedge clock);
    verify();
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    exp_cnt     = 0;
    shown       = '0;
    shown_known = 1'b0;

    // reset values
    cycle(1'b1, mk(32'h77, 6'h3F), 1'b0, 1'b1, 1'b1);
    check("rst_out_vec", 128'(out_vec), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));

    // streaming
    cycle(1'b1, mk(32'h10, 6'h04), 1'b1);
    check("stream_0", 128'(bus.out_alu_result), 128'(32'h10));
    cycle(1'b1, mk(32'h20, 6'h04), 1'b1);
    check("stream_1", 128'(bus.out_alu_result), 128'(32'h20));
    cycle(1'b1, mk(32'h30, 6'h04), 1'b1);
    check("stream_2", 128'(bus.out_alu_result), 128'(32'h30));
    cycle(1'b0, '0, 1'b1);
    check("stream_end_valid", 128'(bus.out_valid), 128'(0));

    // skid
    do_reset();
    cycle(1'b1, mk(32'h10, 6'h01), 1'b0);
    cycle(1'b1, mk(32'h20, 6'h02), 1'b0);
    check("skid_in_ready", 128'(bus.in_ready), 128'(0));
    check("skid_head", 128'(bus.out_alu_result), 128'(32'h10));
    cycle(1'b1, mk(32'h99, 6'h02), 1'b0);
    cycle(1'b0, '0, 1'b1);
    check("skid_second", 128'(bus.out_alu_result), 128'(32'h20));
    check("skid_ready_back", 128'(bus.in_ready), 128'(1));
    check("skid_stalls", 128'(bus.stall_count), 128'(2));
    cycle(1'b0, '0, 1'b1);
    check("skid_drained", 128'(bus.out_valid), 128'(0));

    // flush with full skid, concurrent incoming entry dropped
    do_reset();
    cycle(1'b1, mk(32'hA, 6'h3F), 1'b0);
    cycle(1'b1, mk(32'hB, 6'h3F), 1'b0);
    cycle(1'b1, mk(32'hC, 6'h3F), 1'b0, 1'b1);
    check("flush_valid", 128'(bus.out_valid), 128'(0));
    check("flush_reg_write", 128'(bus.out_reg_write), 128'(0));
    check("flush_in_ready", 128'(bus.in_ready), 128'(1));
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

    // bubble gating after drain
    do_reset();
    cycle(1'b1, mk(32'h55, 6'b010100), 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("bubble_mem_write", 128'(bus.out_mem_write), 128'(0));
    check("bubble_reg_write", 128'(bus.out_reg_write), 128'(0));
    check("bubble_data_held", 128'(bus.out_alu_result), 128'(32'h55));

    // saturation
    do_reset();
    cycle(1'b1, mk(32'h1, 6'h08), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0);
    check("sat_count", 128'(bus.stall_count), 128'(15));

    // reset mid-stall with both registers full and concurrent flush
    do_reset();
    cycle(1'b1, mk(32'h3, 6'h3F), 1'b0);
    cycle(1'b1, mk(32'h4, 6'h3F), 1'b0);
    cycle(1'b1, mk(32'h5, 6'h3F), 1'b0, 1'b1, 1'b1);
    check("rst_mid_vec", 128'(out_vec), 128'(0));
    check("rst_mid_ready", 128'(bus.in_ready), 128'(1));
    check("rst_mid_cnt", 128'(bus.stall_count), 128'(0));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0),
            mk($urandom, 6'($urandom_range(0, 63))),
            bit'($urandom_range(0, 2) != 0),
            bit'($urandom_range(0, 24) == 0),
            bit'($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
